// File: rtl/x25519_pkg.sv
// Shared definitions for the X25519 arithmetic blocks: FSM state encoding,
// iteration counter width and the curve prime.
package x25519_pkg;

  // Iteration counter width; wide enough for operand widths up to 2047 bits
  localparam int CNT_W = 11;

  // Curve prime 2^255 - 19
  localparam logic [255:0] P25519 =
    256'h7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFED;

  // Sequencer states shared by the inverter and the multiplier
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_LOOP  = 3'd2,
    S_FINAL = 3'd3,
    S_POST  = 3'd4
  } state_t;

endpackage

// File: rtl/mont_mul_step.sv
// One radix-2 Montgomery iteration: add b when the multiplier bit is set,
// add m when needed to make the sum even, then halve. With t < 2m and b < m
// the intermediate sum stays below 4m, so N+2 bits never overflow.
module mont_mul_step #(
  parameter int N = 255
) (
  input  logic [N+1:0] t,
  input  logic         a0,
  input  logic [N-1:0] b,
  input  logic [N-1:0] m,
  output logic [N+1:0] t_next
);

  logic [N+1:0] u;
  logic [N+1:0] s;

  // Conditional add of b, parity-fixing add of m, exact halving
  always_comb begin
    u      = t + (a0 ? {2'b00, b} : '0);
    s      = u + (u[0] ? {2'b00, m} : '0);
    t_next = s >> 1;
  end

endmodule

// File: rtl/mont_mul.sv
// Bit-serial radix-2 Montgomery multiplier: R = A*B*2^-N mod M (M odd).
// One multiplier bit per cycle; result after N+3 cycles from acceptance.
// Handshake: a request is taken on a clock edge where the block is idle and
// req_valid is high; req_ready pulses for one cycle to acknowledge it and
// req_busy stays high until the result appears. res_valid/R/res_err then
// hold until an edge sees res_ready high.
// Optional build macro MONT_MUL_RANGE_CHECK_EN: rejects even m, a >= m or
// b >= m with res_err=1 and R=0 after 3 cycles; otherwise res_err is 0.
module mont_mul
  import x25519_pkg::*;
#(
  parameter int N = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] M,
  output logic [N-1:0] R,
  input  logic         req_valid,
  output logic         req_ready,
  output logic         req_busy,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_err
);

  state_t           state;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic [N-1:0]     m;
  logic [N+1:0]     t;
  logic [N+1:0]     t_next;
  logic [CNT_W-1:0] i;
  logic [N-1:0]     fin;

  mont_mul_step #(.N(N)) u_step (
    .t      (t),
    .a0     (a[0]),
    .b      (b),
    .m      (m),
    .t_next (t_next)
  );

  // Final conditional subtraction brings T from [0, 2m) into [0, m)
  always_comb begin
    fin = N'((t >= {2'b00, m}) ? (t - {2'b00, m}) : t);
  end

`ifdef MONT_MUL_RANGE_CHECK_EN
  logic err;
  assign res_err = err;
`else
  assign res_err = 1'b0;
`endif

  // Sequencer: operand latch, N iterations, reduction, result hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      a         <= '0;
      b         <= '0;
      m         <= '0;
      t         <= '0;
      i         <= '0;
      R         <= '0;
      req_ready <= 1'b0;
      req_busy  <= 1'b0;
      res_valid <= 1'b0;
`ifdef MONT_MUL_RANGE_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            a         <= A;
            b         <= B;
            m         <= M;
            req_ready <= 1'b1;
            req_busy  <= 1'b1;
            state     <= S_READY;
          end
        end
        S_READY: begin
          req_ready <= 1'b0;
          t         <= '0;
          i         <= '0;
`ifdef MONT_MUL_RANGE_CHECK_EN
          if (!m[0] || (a >= m) || (b >= m)) begin
            err   <= 1'b1;
            state <= S_FINAL;
          end else begin
            state <= S_LOOP;
          end
`else
          state <= S_LOOP;
`endif
        end
        S_LOOP: begin
          t <= t_next;
          a <= a >> 1;
          i <= i + 1'b1;
          if (i == CNT_W'(N - 1)) state <= S_FINAL;
        end
        S_FINAL: begin
`ifdef MONT_MUL_RANGE_CHECK_EN
          R <= err ? '0 : fin;
`else
          R <= fin;
`endif
          res_valid <= 1'b1;
          req_busy  <= 1'b0;
          state     <= S_POST;
        end
        S_POST: begin
          if (res_ready) begin
            res_valid <= 1'b0;
`ifdef MONT_MUL_RANGE_CHECK_EN
            err       <= 1'b0;
`endif
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_mul.sv
// Bench for mont_mul: an 8-bit instance for directed/boundary/random cases
// and a 255-bit instance on the X25519 prime, checked against a modular
// arithmetic reference (A*B mod M times the inverse of 2^N).
module tb_mont_mul;
  import x25519_pkg::*;

  logic clk;
  logic rst;

  // Small instance (N=8)
  logic [7:0] s_a, s_b, s_m, s_r;
  logic s_req_valid, s_req_ready, s_req_busy, s_res_valid, s_res_ready, s_res_err;
  // Large instance (N=255)
  logic [254:0] g_a, g_b, g_m, g_r;
  logic g_req_valid, g_req_ready, g_req_busy, g_res_valid, g_res_ready, g_res_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic cur_big;
  wire         cur_res_valid = cur_big ? g_res_valid : s_res_valid;
  wire         cur_req_ready = cur_big ? g_req_ready : s_req_ready;
  wire         cur_req_busy  = cur_big ? g_req_busy  : s_req_busy;
  wire         cur_res_err   = cur_big ? g_res_err   : s_res_err;
  wire [254:0] cur_r         = cur_big ? g_r : {247'b0, s_r};

  mont_mul #(.N(8)) u_small (
    .clk(clk), .rst(rst), .A(s_a), .B(s_b), .M(s_m), .R(s_r),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_busy(s_req_busy),
    .res_valid(s_res_valid), .res_ready(s_res_ready), .res_err(s_res_err)
  );

  mont_mul #(.N(255)) u_big (
    .clk(clk), .rst(rst), .A(g_a), .B(g_b), .M(g_m), .R(g_r),
    .req_valid(g_req_valid), .req_ready(g_req_ready), .req_busy(g_req_busy),
    .res_valid(g_res_valid), .res_ready(g_res_ready), .res_err(g_res_err)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [254:0] obs, input logic [254:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: (a*b mod m) * (2^-1)^n mod m, with 2^-1 = (m+1)/2 for odd m
  function automatic logic [254:0] ref_mont(input logic [254:0] a, input logic [254:0] b,
                                           input logic [254:0] m, input int n);
    logic [511:0] mm, prod, h, inv;
    mm   = {257'b0, m};
    prod = ({257'b0, a} * {257'b0, b}) % mm;
    h    = (mm + 512'd1) >> 1;
    inv  = 512'd1;
    for (int k = 0; k < n; k++) inv = (inv * h) % mm;
    return 255'((prod * inv) % mm);
  endfunction

  function automatic logic [254:0] pow_mod(input logic [254:0] base, input logic [254:0] e,
                                          input logic [254:0] m);
    logic [511:0] mm, acc, bb;
    mm  = {257'b0, m};
    acc = 512'd1;
    bb  = {257'b0, base} % mm;
    for (int k = 254; k >= 0; k--) begin
      acc = (acc * acc) % mm;
      if (e[k]) acc = (acc * bb) % mm;
    end
    return 255'(acc);
  endfunction

  function automatic logic [254:0] rnd255();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return 255'(v);
  endfunction

  task automatic drive_req(input bit big, input logic [254:0] a, input logic [254:0] b,
                           input logic [254:0] m, input logic v);
    if (big) begin
      g_a = a; g_b = b; g_m = m; g_req_valid = v;
    end else begin
      s_a = a[7:0]; s_b = b[7:0]; s_m = m[7:0]; s_req_valid = v;
    end
  endtask

  task automatic set_res_ready(input bit big, input logic v);
    if (big) g_res_ready = v;
    else s_res_ready = v;
  endtask

  // One complete transaction with handshake checks; returns R, err, latency
  task automatic run_op(input bit big, input logic [254:0] a, input logic [254:0] b,
                        input logic [254:0] m, input bit noise, input bit early,
                        input int hold, output logic [254:0] r, output logic err,
                        output int lat);
    bit stable, rr_extra, busy_ok;
    cur_big = big;
    @(negedge clk);
    drive_req(big, a, b, m, 1'b1);
    set_res_ready(big, early);
    @(posedge clk); #1;
    check("req_ready_pulse", 255'(cur_req_ready), 255'(1));
    check("req_busy_set", 255'(cur_req_busy), 255'(1));
    drive_req(big, a, b, m, 1'b0);
    lat = 1; rr_extra = 0; busy_ok = 1;
    while (!cur_res_valid && lat < 2000) begin
      if (noise) drive_req(big, rnd255(), rnd255(), rnd255(), 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
      lat++;
      if (cur_req_ready) rr_extra = 1;
      if (!cur_res_valid && !cur_req_busy) busy_ok = 0;
    end
    drive_req(big, '0, '0, '0, 1'b0);
    check("result_timeout", 255'(lat < 2000), 255'(1));
    check("req_ready_single", 255'(rr_extra), 255'(0));
    check("busy_held", 255'(busy_ok), 255'(1));
    check("busy_clear", 255'(cur_req_busy), 255'(0));
    r   = cur_r;
    err = cur_res_err;
    if (early) begin
      @(posedge clk); #1;
      check("res_valid_one_cycle", 255'(cur_res_valid), 255'(0));
      set_res_ready(big, 1'b0);
    end else begin
      stable = 1;
      for (int k = 0; k < hold; k++) begin
        if (noise) drive_req(big, rnd255(), rnd255(), rnd255(), 1'($urandom_range(0, 1)));
        @(posedge clk); #1;
        if (!cur_res_valid || cur_r !== r || cur_req_ready) stable = 0;
      end
      drive_req(big, '0, '0, '0, 1'b0);
      if (hold > 0) check("hold_stable", 255'(stable), 255'(1));
      @(negedge clk);
      set_res_ready(big, 1'b1);
      @(posedge clk); #1;
      check("res_valid_clear", 255'(cur_res_valid), 255'(0));
      check("res_err_clear", 255'(cur_res_err), 255'(0));
      set_res_ready(big, 1'b0);
    end
  endtask

  // Directed and random sequence
  initial begin
    logic [254:0] r, a, b, m, p, exp_r, inv9;
    logic err;
    int lat;
    logic [254:0] sa [5];
    logic [254:0] sb [5];
    logic [254:0] se [5];

    cur_big = 1'b0;
    rst = 1'b1;
    drive_req(1'b0, '0, '0, '0, 1'b0);
    drive_req(1'b1, '0, '0, '0, 1'b0);
    s_res_ready = 1'b0;
    g_res_ready = 1'b0;
    p = P25519[254:0];

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_r_small", {247'b0, s_r}, '0);
    check("rst_outs_small", 255'({s_req_ready, s_req_busy, s_res_valid, s_res_err}), '0);
    check("rst_r_big", g_r, '0);
    check("rst_outs_big", 255'({g_req_ready, g_req_busy, g_res_valid, g_res_err}), '0);
    @(negedge clk);
    rst = 1'b0;

    // Small directed cases, M=251
    sa[0] = 1;   sb[0] = 1;   se[0] = 201;
    sa[1] = 5;   sb[1] = 1;   se[1] = 1;
    sa[2] = 250; sb[2] = 250; se[2] = 201;
    sa[3] = 0;   sb[3] = 77;  se[3] = 0;
    sa[4] = 77;  sb[4] = 0;   se[4] = 0;
    for (int k = 0; k < 5; k++) begin
      run_op(1'b0, sa[k], sb[k], 255'd251, 1'b0, 1'b0, 0, r, err, lat);
      check("small_directed_r", r, se[k]);
      check("small_directed_err", 255'(err), '0);
      check("small_latency", 255'(lat), 255'(11));
    end

    // Result held with res_ready low, request pulses ignored
    exp_r = ref_mont(255'd123, 255'd45, 255'd251, 8);
    run_op(1'b0, 255'd123, 255'd45, 255'd251, 1'b1, 1'b0, 20, r, err, lat);
    check("hold_r", r, exp_r);

    // res_ready already high when result appears, then back-to-back request
    exp_r = ref_mont(255'd200, 255'd199, 255'd251, 8);
    run_op(1'b0, 255'd200, 255'd199, 255'd251, 1'b0, 1'b1, 0, r, err, lat);
    check("early_r", r, exp_r);
    exp_r = ref_mont(255'd17, 255'd3, 255'd241, 8);
    run_op(1'b0, 255'd17, 255'd3, 255'd241, 1'b0, 1'b0, 0, r, err, lat);
    check("after_early_r", r, exp_r);

    // Small random, random odd modulus
    for (int k = 0; k < 200; k++) begin
      m = 255'($urandom_range(1, 127) * 2 + 1);
      a = 255'($urandom_range(0, int'(m) - 1));
      b = 255'($urandom_range(0, int'(m) - 1));
      exp_r = ref_mont(a, b, m, 8);
      run_op(1'b0, a, b, m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), r, err, lat);
      check("small_rand_r", r, exp_r);
      check("small_rand_lat", 255'(lat), 255'(11));
    end

    // Even modulus
    run_op(1'b0, 255'd5, 255'd7, 255'd250, 1'b0, 1'b0, 0, r, err, lat);
`ifdef MONT_MUL_RANGE_CHECK_EN
    check("range_err", 255'(err), 255'(1));
    check("range_r", r, '0);
    check("range_lat", 255'(lat), 255'(3));
`else
    check("range_err", 255'(err), '0);
    check("range_lat", 255'(lat), 255'(11));
`endif

    // Affine conversion: (9^-1 * 2^255) * 9 * 2^-255 = 1 mod p
    inv9 = pow_mod(255'd9, p - 255'd2, p);
    a = 255'(({257'b0, inv9} * 512'd19) % {257'b0, p});
    run_op(1'b1, a, 255'd9, p, 1'b0, 1'b0, 0, r, err, lat);
    check("chain_r", r, 255'd1);
    check("big_latency", 255'(lat), 255'(258));

    // Large random on the prime
    for (int k = 0; k < 40; k++) begin
      a = rnd255() % p;
      b = rnd255() % p;
      exp_r = ref_mont(a, b, p, 255);
      run_op(1'b1, a, b, p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 2), r, err, lat);
      check("big_rand_r", r, exp_r);
    end

    // Asynchronous reset in the middle of the iteration loop
    cur_big = 1'b1;
    @(negedge clk);
    drive_req(1'b1, rnd255() % p, rnd255() % p, p, 1'b1);
    @(posedge clk); #1;
    drive_req(1'b1, '0, '0, '0, 1'b0);
    repeat (50) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_r", g_r, '0);
    check("midrst_outs", 255'({g_req_ready, g_req_busy, g_res_valid, g_res_err}), '0);
    @(negedge clk);
    rst = 1'b0;
    a = rnd255() % p;
    b = rnd255() % p;
    exp_r = ref_mont(a, b, p, 255);
    run_op(1'b1, a, b, p, 1'b0, 1'b0, 0, r, err, lat);
    check("post_rst_r", r, exp_r);
    check("post_rst_lat", 255'(lat), 255'(258));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mont_mul.md
# mont_mul

Bit-serial radix-2 Montgomery modular multiplier. Computes R = A·B·2^-N mod M for odd M. It sits directly downstream of `inv_montgomery` in the X25519 affine-conversion path. Multiplying the inverter's Montgomery-domain result Z^-1·2^N by X yields X·Z^-1 mod M. Its request/result handshake is identical to the inverter's, so the two chain without glue logic.

## Interface
Parameters:
- N, 255, operand and modulus width in bits

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; asynchronous, active-high
- A  in  N  multiplicand, 0..M-1; sampled on request acceptance
- B  in  N  multiplier, 0..M-1; sampled on request acceptance
- M  in  N  odd modulus; sampled on request acceptance
- R  out  N  result A·B·2^-N mod M, in 0..M-1
- req_valid  in  1  request strobe
- req_ready  out  1  one-cycle pulse acknowledging the request
- req_busy  out  1  high from acceptance until the result is presented
- res_valid  out  1  result valid; held until res_ready
- res_ready  in  1  result consumed
- res_err  out  1  invalid-operand flag; valid while res_valid is high

## Operation
- States: S_IDLE, S_READY, S_LOOP, S_FINAL, S_POST.
- S_IDLE:
  - On req_valid, latch A→a, B→b, M→m.
  - Set req_ready=1 and req_busy=1.
  - Go to S_READY.
- S_READY:
  - Set req_ready=0, T=0, i=0.
  - Go to S_LOOP, or go to S_FINAL with the error path described under Configuration.
- S_LOOP, one iteration per cycle:
  - U = T + (a[0] ? b : 0); then T ← (U + (U[0] ? m : 0)) >> 1.
  - Shift a right by 1; i ← i+1.
  - After iteration i = N-1, go to S_FINAL.
- S_FINAL:
  - R ← (T ≥ m) ? T − m : T.
  - Set res_valid=1, req_busy=0.
  - Go to S_POST.
- S_POST: on res_ready, set res_valid=0, res_err=0, and return to S_IDLE.
- Width rules:
  - T is N+2 bits. The invariant T < 2m holds throughout, so no overflow occurs.
  - U is N+2 bits; the sum before the shift needs N+2 bits.
  - Iteration counter i is 11 bits.
  - The final subtraction is done at N+2 bits and the result is truncated to N bits.
- req_valid is ignored in every state except S_IDLE. Inputs may change freely after acceptance.
- A=0 or B=0 yields R=0.

## Timing
- Reset values: R=0, req_ready=0, req_busy=0, res_valid=0, res_err=0; state S_IDLE; T=0; i=0.
- Asynchronous reset mid-operation aborts the computation immediately. The block is then ready for a new request on the first clock after rst deasserts.
- Call the edge that samples req_valid=1 in S_IDLE "edge 0".
  - req_ready is high for exactly one cycle after edge 0.
  - res_valid rises after edge N+2, i.e. N+3 cycles per operation (258 for N=255).
- If res_ready is already high when res_valid rises, res_valid stays high for one cycle. The next request is then accepted at the earliest one cycle after the block re-enters S_IDLE.
- res_valid and R are stable while res_ready is low.

## Configuration
- MONT_MUL_RANGE_CHECK_EN defined:
  - In S_READY, check for m even, a ≥ m, or b ≥ m.
  - Any of these skips S_LOOP and goes to S_FINAL with R=0 and res_err=1. Result latency is 3 cycles.
- MONT_MUL_RANGE_CHECK_EN undefined:
  - No checks are made; res_err is tied to 0.
  - Out-of-range operands give an unspecified R, but the timing is unchanged.

## Structure
- Shared package `x25519_pkg` holds:
  - The state encoding localparams.
  - The curve constant P25519 = 2^255−19.
  - The counter width, 11 bits.
- Sub-module `mont_mul_step`: a combinational single iteration (T, a0, b, m → T_next). It is reused by a future radix-4 variant.
- Top-level target: about 150–250 lines.

## Test plan
- N=8, M=251, A=1, B=1 → R=201 (2^-8 mod 251); res_valid after 11 cycles; res_err=0.
- N=8, M=251: A=5, B=1 → R=1; A=250, B=250 → R=201; A=0, B=77 → R=0.
- N=255, M=2^255−19: chain with `inv_montgomery` (real_inverse=0) on Z=9, then multiply by X=9 → R=1; 1000 random A,B against a software model.
- res_ready held low for 20 cycles → R and res_valid stable; req_valid pulses during busy are ignored.
- rst asserted mid-S_LOOP → all outputs 0 asynchronously; a fresh request after release → correct R.
- With MONT_MUL_RANGE_CHECK_EN: M=250 → res_err=1, R=0 after 3 cycles. Without the macro: same stimulus → res_err=0, full latency.
